// File: rtl/wb_burst_master_if.sv
// Wishbone B3 master/slave signal bundle used between wb_burst_master and
// the SDRAM controller's Wishbone slave port.
interface wb_burst_master_if #(
    parameter int AW = 26,
    parameter int DW = 32
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_addr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic            wb_ack_i;
    logic [DW-1:0]   wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_burst_master.sv
// Converts single line requests into incrementing Wishbone B3 bursts, one
// request outstanding, with a no-ack timeout that aborts a stalled cycle.
module wb_burst_master #(
    parameter int AW   = 26,
    parameter int DW   = 32,
    parameter int LW   = 9,
    parameter int TO_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,

    input  logic              req_i,
    input  logic              req_we_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [LW-1:0]     req_len_i,
    output logic              req_ack_o,

    input  logic [DW-1:0]     wr_data_i,
    input  logic [DW/8-1:0]   wr_sel_i,
    output logic              wr_next_o,

    output logic [DW-1:0]     rd_data_o,
    output logic              rd_valid_o,

    output logic              done_o,
    output logic              err_o,

    wb_burst_master_if.master wb
);
    localparam int BYTES = DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    // Counter value during the last tolerated ack-less cycle: the increment
    // that would reach all-ones ends the cycle instead.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    logic [1:0]      state;
    logic            we_q;
    logic            cyc_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   rem;
    logic [2:0]      cti_q;
    logic [TO_W-1:0] to_cnt;

    logic [LW-1:0]   len_eff;
    logic            in_bus;
    logic            wr_beat;

    assign len_eff = (req_len_i == '0) ? LW'(1) : req_len_i;
    assign in_bus  = (state == ST_BUS);
    assign wr_beat = in_bus & we_q;

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = cyc_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_cti_o  = cti_q;

    // Write data and byte enables flow straight from the source so a beat can
    // be consumed in the same cycle the slave acks it.
    assign wb.wb_dat_o = wr_beat ? wr_data_i : '0;
    assign wb.wb_sel_o = wr_beat ? wr_sel_i : (in_bus ? '1 : '0);
    assign wr_next_o   = wr_beat & wb.wb_ack_i;

    // NOTE: every register below uses <= so all of them see the pre-edge
    // values; a blocking assignment here would create an ordering-dependent
    // mix of old and new state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            addr_q     <= '0;
            rem        <= '0;
            cti_q      <= CTI_CLASSIC;
            to_cnt     <= '0;
            req_ack_o  <= 1'b0;
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            req_ack_o  <= 1'b0;
            rd_valid_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        state     <= ST_BUS;
                        we_q      <= req_we_i;
                        cyc_q     <= 1'b1;
                        addr_q    <= req_addr_i;
                        rem       <= len_eff;
                        cti_q     <= (len_eff == LW'(1)) ? CTI_CLASSIC : CTI_INCR;
                        to_cnt    <= '0;
                        req_ack_o <= 1'b1;
                    end
                end

                ST_BUS: begin
                    if (wb.wb_ack_i) begin
                        to_cnt <= '0;
                        addr_q <= addr_q + AW'(BYTES);
                        rem    <= rem - LW'(1);
                        if (!we_q) begin
                            rd_data_o  <= wb.wb_dat_i;
                            rd_valid_o <= 1'b1;
                        end
                        if (rem == LW'(1)) begin
                            state  <= ST_FIN;
                            cyc_q  <= 1'b0;
                            we_q   <= 1'b0;
                            cti_q  <= CTI_CLASSIC;
                            done_o <= 1'b1;
                        end else if (rem == LW'(2)) begin
                            cti_q <= CTI_END;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state  <= ST_IDLE;
                        cyc_q  <= 1'b0;
                        we_q   <= 1'b0;
                        cti_q  <= CTI_CLASSIC;
                        to_cnt <= '0;
                        err_o  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed scenarios plus randomized bursts, each
// cycle compared against a beat-level model of the burst.
module tb_wb_burst_master;
    localparam int AW       = 26;
    localparam int DW       = 32;
    localparam int LW       = 9;
    localparam int TO_W     = 8;
    localparam int TO_LIMIT = (1 << TO_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_i;
    logic              req_we_i;
    logic [AW-1:0]     req_addr_i;
    logic [LW-1:0]     req_len_i;
    logic              req_ack_o;
    logic [DW-1:0]     wr_data_i;
    logic [DW/8-1:0]   wr_sel_i;
    logic              wr_next_o;
    logic [DW-1:0]     rd_data_o;
    logic              rd_valid_o;
    logic              done_o;
    logic              err_o;

    wb_burst_master_if #(.AW(AW), .DW(DW)) wb ();

    wb_burst_master #(.AW(AW), .DW(DW), .LW(LW), .TO_W(TO_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_len_i  (req_len_i),
        .req_ack_o  (req_ack_o),
        .wr_data_i  (wr_data_i),
        .wr_sel_i   (wr_sel_i),
        .wr_next_o  (wr_next_o),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .wb         (wb.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_ack = 0;

    bit            use_seq;
    logic [DW-1:0] seq_base;
    logic [DW-1:0] seq_step;
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},     wb.wb_cyc_o,  0);
        check({tag, "_stb"},     wb.wb_stb_o,  0);
        check({tag, "_we"},      wb.wb_we_o,   0);
        check({tag, "_addr"},    wb.wb_addr_o, 0);
        check({tag, "_cti"},     wb.wb_cti_o,  0);
        check({tag, "_req_ack"}, req_ack_o,    0);
        check({tag, "_rd_val"},  rd_valid_o,   0);
        check({tag, "_rd_data"}, rd_data_o,    0);
        check({tag, "_done"},    done_o,       0);
        check({tag, "_err"},     err_o,        0);
        check({tag, "_wr_next"}, wr_next_o,    0);
        check({tag, "_dat_o"},   wb.wb_dat_o,  0);
        check({tag, "_sel"},     wb.wb_sel_o,  0);
    endtask

    // One request from capture to completion. stop_after >= 0 makes the slave
    // go silent after that many beats; rst_beat >= 0 resets during that beat.
    task automatic run_burst(input bit we, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int wmin, input int wmax, input int stop_after,
                             input int rst_beat, input bit hold_req, input bit b2b);
        int            n;
        int            beat;
        int            idle;
        int            waits;
        bit            ack;
        bit            first;
        bit            rd_pend;
        logic [DW-1:0] d;
        logic [AW-1:0] a_exp;
        logic [2:0]    cti_exp;

        n = (len == '0) ? 1 : int'(len);
        req_i      = 1'b1;
        req_we_i   = we;
        req_addr_i = addr;
        req_len_i  = len;
        step();
        check("req_ack", req_ack_o, 1);
        if (b2b) check("b2b_gap", 64'(cyc_n - last_ack), 3);
        if (!hold_req) req_i = 1'b0;

        beat    = 0;
        idle    = 0;
        first   = 1'b1;
        rd_pend = 1'b0;
        waits   = $urandom_range(wmax, wmin);
        forever begin
            a_exp   = addr + AW'(4 * beat);
            cti_exp = (n == 1) ? 3'b000 : ((beat == n - 1) ? 3'b111 : 3'b010);
            check("cyc", wb.wb_cyc_o, 1);
            check("stb", wb.wb_stb_o, 1);
            check("we", wb.wb_we_o, 64'(we));
            check("addr", wb.wb_addr_o, 64'(a_exp));
            check("cti", wb.wb_cti_o, 64'(cti_exp));
            check("rd_valid", rd_valid_o, 64'(rd_pend));
            check("rd_data", rd_data_o, 64'(last_rd));
            check("done_bus", done_o, 0);
            check("err_bus", err_o, 0);
            if (!first) check("req_ack_bus", req_ack_o, 0);
            first = 1'b0;

            if (beat == rst_beat) begin
                rst = 1'b1;
                wb.wb_ack_i = 1'b0;
                step();
                rst = 1'b0;
                last_rd = '0;
                #1;
                check_all_zero("rst");
                step();
                check("rst_done", done_o, 0);
                check("rst_err", err_o, 0);
                check("rst_cyc", wb.wb_cyc_o, 0);
                return;
            end

            ack = (stop_after >= 0 && beat >= stop_after) ? 1'b0 : (waits == 0);
            d   = use_seq ? seq_base + seq_step * DW'(beat) : DW'($urandom);
            wb.wb_ack_i = ack;
            if (we) begin
                wr_data_i = d;
                wr_sel_i  = use_seq ? '1 : (DW/8)'($urandom);
                wb.wb_dat_i = DW'($urandom);
            end else begin
                wr_data_i = DW'($urandom);
                wr_sel_i  = (DW/8)'($urandom);
                wb.wb_dat_i = d;
            end
            #1;
            check("wr_next", wr_next_o, 64'(we & ack));
            check("dat_o", wb.wb_dat_o, we ? 64'(d) : 64'(0));
            check("sel", wb.wb_sel_o, we ? 64'(wr_sel_i) : 64'({(DW/8){1'b1}}));
            if (ack) last_ack = cyc_n;

            step();
            wb.wb_ack_i = 1'b0;
            rd_pend = 1'b0;
            if (ack) begin
                if (!we) begin
                    rd_pend = 1'b1;
                    last_rd = d;
                end
                beat++;
                idle  = 0;
                waits = $urandom_range(wmax, wmin);
            end else begin
                if (waits > 0) waits--;
                idle++;
            end

            if (beat == n) begin
                check("fin_cyc", wb.wb_cyc_o, 0);
                check("fin_done", done_o, 1);
                check("fin_err", err_o, 0);
                check("fin_rd_valid", rd_valid_o, 64'(rd_pend));
                check("fin_rd_data", rd_data_o, 64'(last_rd));
                step();
                check("idle_done", done_o, 0);
                check("idle_cyc", wb.wb_cyc_o, 0);
                check("idle_req_ack", req_ack_o, 0);
                check("idle_rd_valid", rd_valid_o, 0);
                return;
            end
            if (idle == TO_LIMIT) begin
                check("to_cyc", wb.wb_cyc_o, 0);
                check("to_stb", wb.wb_stb_o, 0);
                check("to_err", err_o, 1);
                check("to_done", done_o, 0);
                step();
                check("to_err_pulse", err_o, 0);
                check("to_no_done", done_o, 0);
                check("to_idle_cyc", wb.wb_cyc_o, 0);
                return;
            end
        end
    endtask

    initial begin
        bit            prev_hold;
        bit            hold;
        logic [AW-1:0] a;

        rst         = 1'b1;
        req_i       = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_len_i   = '0;
        wr_data_i   = '0;
        wr_sel_i    = '0;
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = '0;
        use_seq     = 1'b0;
        seq_base    = '0;
        seq_step    = '0;
        last_rd     = '0;
        step();
        step();
        rst = 1'b0;
        check_all_zero("reset");

        // Stray acks while no cycle is open.
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stray_wr_next", wr_next_o, 0);
            step();
            check("stray_cyc", wb.wb_cyc_o, 0);
            check("stray_rd_valid", rd_valid_o, 0);
            check("stray_done", done_o, 0);
            check("stray_rd_data", rd_data_o, 0);
        end
        wb.wb_ack_i = 1'b0;

        use_seq = 1'b1;
        seq_base = 32'hDEAD_BEEF; seq_step = '0;
        run_burst(1'b0, 26'h100, 9'd1, 2, 2, -1, -1, 1'b0, 1'b0);

        seq_base = 32'h11; seq_step = 32'h11;
        run_burst(1'b1, 26'h200, 9'd4, 1, 1, -1, -1, 1'b0, 1'b0);

        seq_base = 32'h0; seq_step = 32'h1;
        run_burst(1'b0, 26'h1000, 9'd8, 0, 0, -1, -1, 1'b0, 1'b0);

        use_seq = 1'b0;
        run_burst(1'b0, 26'h2000, 9'd4, 0, 0, 2, -1, 1'b0, 1'b0);
        run_burst(1'b0, 26'h2100, 9'd3, 0, 1, -1, -1, 1'b0, 1'b0);

        run_burst(1'b0, 26'h3000, 9'd8, 0, 0, -1, 2, 1'b0, 1'b0);
        run_burst(1'b1, 26'h3100, 9'd2, 0, 0, -1, -1, 1'b0, 1'b0);

        run_burst(1'b0, 26'h300, 9'd0, 0, 0, -1, -1, 1'b1, 1'b0);
        run_burst(1'b0, 26'h400, 9'd2, 0, 0, -1, -1, 1'b0, 1'b1);

        // Address wrap at the top of the byte address space.
        run_burst(1'b1, 26'h3FF_FFF8, 9'd4, 0, 1, -1, -1, 1'b0, 1'b0);

        prev_hold = 1'b0;
        for (int i = 0; i < 24; i++) begin
            a = AW'($urandom) & ~AW'(3);
            if (i % 6 == 0) a = 26'h3FF_FFF0;
            hold = (i != 23) && ($urandom_range(3, 0) == 0);
            run_burst(1'($urandom_range(1, 0)), a, LW'($urandom_range(12, 0)),
                      0, 3, -1, -1, hold, prev_hold);
            prev_hold = hold;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
